// File: rtl/bp_be_prefetch_inserter_pkg.sv
// Shared backend types for the loop-stride prefetch path: the inserter FSM states
// and the loop descriptor handed from loop inference to the prefetch inserter.
package bp_be_prefetch_inserter_pkg;

  localparam int unsigned pf_vaddr_width_lp  = 39;
  localparam int unsigned pf_stride_width_lp = 8;
  localparam int unsigned pf_range_width_lp  = 8;

  typedef enum logic {
    e_pf_idle,
    e_pf_issue
  } bp_be_pf_state_e;

  typedef struct packed {
    logic [pf_range_width_lp-1:0]  remaining;
    logic [pf_stride_width_lp-1:0] stride;
    logic [pf_vaddr_width_lp-1:0]  base;
    logic [pf_vaddr_width_lp-1:0]  pc;
  } bp_be_loop_desc_s;

endpackage

// File: rtl/bp_be_pf_addr_gen.sv
// Combinational address arithmetic for the prefetch inserter: stride sign-extension,
// run-ahead start address, next-iteration address and the page/line comparisons.
module bp_be_pf_addr_gen
  import bp_be_prefetch_inserter_pkg::*;
#(
  parameter int unsigned vaddr_width_p        = 39,
  parameter int unsigned stride_width_p       = 8,
  parameter int unsigned prefetch_distance_p  = 4,
  parameter int unsigned block_offset_width_p = 6,
  parameter int unsigned page_offset_width_p  = 12
) (
  input  logic [vaddr_width_p-1:0]                      base_addr,
  input  logic [stride_width_p-1:0]                     stride,
  input  logic [vaddr_width_p-1:0]                      cur_addr,
  input  logic [vaddr_width_p-block_offset_width_p-1:0] last_line,
  output logic [vaddr_width_p-1:0]                      start_addr,
  output logic                                          start_same_page,
  output logic [vaddr_width_p-1:0]                      next_addr,
  output logic                                          next_same_page,
  output logic                                          same_line
);

  localparam logic [vaddr_width_p-1:0] distance_lp = vaddr_width_p'(prefetch_distance_p);

  logic signed [vaddr_width_p-1:0] stride_s;

  assign stride_s   = {{(vaddr_width_p-stride_width_p){stride[stride_width_p-1]}}, stride};
  // Modular add: a wrap past the top of the address space shows up as a page change.
  assign start_addr = base_addr + distance_lp * stride_s;
  assign next_addr  = cur_addr + stride_s;

  assign start_same_page = (start_addr[vaddr_width_p-1:page_offset_width_p]
                            == base_addr[vaddr_width_p-1:page_offset_width_p]);
  assign next_same_page  = (next_addr[vaddr_width_p-1:page_offset_width_p]
                            == cur_addr[vaddr_width_p-1:page_offset_width_p]);
  assign same_line       = (cur_addr[vaddr_width_p-1:block_offset_width_p] == last_line);

endmodule

// File: rtl/bp_be_prefetch_inserter.sv
// Turns confirmed loop/stride descriptors into a stream of data-prefetch requests.
// Optional BP_BE_PREFETCH_LINE_DEDUP_EN suppresses repeat requests to the same cache line.
module bp_be_prefetch_inserter
  import bp_be_prefetch_inserter_pkg::*;
#(
  parameter int unsigned vaddr_width_p        = 39,
  parameter int unsigned stride_width_p       = 8,
  parameter int unsigned output_range_p       = 8,
  parameter int unsigned max_prefetch_p       = 16,
  parameter int unsigned prefetch_distance_p  = 4,
  parameter int unsigned block_offset_width_p = 6,
  parameter int unsigned page_offset_width_p  = 12
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      loop_v_i,
  output logic                      ready_and_o,
  input  logic [output_range_p-1:0] remaining_iterations_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  base_addr_i,
  input  logic [vaddr_width_p-1:0]  striding_pc_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_vaddr_o,
  output logic [vaddr_width_p-1:0]  pf_pc_o,
  input  logic                      pf_yumi_i,
  output logic                      busy_o
);

  localparam int unsigned line_width_lp = vaddr_width_p - block_offset_width_p;
  localparam logic [output_range_p-1:0] cap_lp = output_range_p'(max_prefetch_p);

  function automatic logic [output_range_p-1:0] clamp_count(input logic [output_range_p-1:0] rem);
    return (rem > cap_lp) ? cap_lp : rem;
  endfunction

  bp_be_pf_state_e             state, state_n;
  logic [output_range_p-1:0]   count, count_n;
  logic [vaddr_width_p-1:0]    addr, addr_n;
  logic [vaddr_width_p-1:0]    pc, pc_n;
  logic [stride_width_p-1:0]   stride, stride_n;
  logic [output_range_p-1:0]   init_count;
  logic [stride_width_p-1:0]   gen_stride;
  logic [vaddr_width_p-1:0]    start_addr, next_addr;
  logic                        start_same_page, next_same_page, same_line;
  logic [line_width_lp-1:0]    last_line;
  logic                        dup, advance, accept;

  assign gen_stride = (state == e_pf_idle) ? stride_i : stride;
  assign init_count = clamp_count(remaining_iterations_i);

  bp_be_pf_addr_gen #(
    .vaddr_width_p        (vaddr_width_p),
    .stride_width_p       (stride_width_p),
    .prefetch_distance_p  (prefetch_distance_p),
    .block_offset_width_p (block_offset_width_p),
    .page_offset_width_p  (page_offset_width_p)
  ) addr_gen (
    .base_addr       (base_addr_i),
    .stride          (gen_stride),
    .cur_addr        (addr),
    .last_line       (last_line),
    .start_addr      (start_addr),
    .start_same_page (start_same_page),
    .next_addr       (next_addr),
    .next_same_page  (next_same_page),
    .same_line       (same_line)
  );

`ifdef BP_BE_PREFETCH_LINE_DEDUP_EN
  logic last_v;

  // Line memory is scoped to one descriptor; flush or a new accept forgets it.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i || accept) begin
      last_v    <= 1'b0;
      last_line <= '0;
    end else if (pf_v_o && pf_yumi_i) begin
      last_v    <= 1'b1;
      last_line <= addr[vaddr_width_p-1:block_offset_width_p];
    end
  end

  assign dup = (state == e_pf_issue) && last_v && same_line;
`else
  logic unused_same_line;

  assign unused_same_line = same_line;
  assign last_line        = '0;
  assign dup              = 1'b0;
`endif

  assign accept      = ready_and_o && loop_v_i;
  assign ready_and_o = (state == e_pf_idle) && !flush_i;
  assign pf_v_o      = (state == e_pf_issue) && !flush_i && !dup;
  assign advance     = (state == e_pf_issue) && !flush_i && (dup || pf_yumi_i);
  assign pf_vaddr_o  = addr;
  assign pf_pc_o     = pc;
  assign busy_o      = (state != e_pf_idle);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= e_pf_idle;
      count  <= '0;
      addr   <= '0;
      pc     <= '0;
      stride <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      addr   <= addr_n;
      pc     <= pc_n;
      stride <= stride_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    addr_n   = addr;
    pc_n     = pc;
    stride_n = stride;
    unique case (state)
      e_pf_idle: begin
        if (accept) begin
          count_n  = init_count;
          addr_n   = start_addr;
          pc_n     = striding_pc_i;
          stride_n = stride_i;
          // Degenerate or page-crossing descriptors are consumed without issuing.
          if ((init_count != '0) && (stride_i != '0) && start_same_page)
            state_n = e_pf_issue;
        end
      end
      e_pf_issue: begin
        if (advance) begin
          count_n = count - output_range_p'(1);
          if ((count == output_range_p'(1)) || !next_same_page)
            state_n = e_pf_idle;
          else
            addr_n = next_addr;
        end
      end
      default: state_n = e_pf_idle;
    endcase
    if (flush_i) begin
      state_n = e_pf_idle;
      count_n = '0;
    end
  end

endmodule

// File: doc/bp_be_prefetch_inserter.md
Name: bp_be_prefetch_inserter

Overview:
- Consumes confirmed loop/stride descriptors from the loop-inference stage and turns them into a stream of synthetic data-prefetch requests.
- The scheduler injects each request into dispatch through a valid/yumi handshake, alongside late writebacks.
- Provides the real consumer for the loop profiler's yumi input: one descriptor accepted per idle period.
- Requests run ahead of the demand stream by a fixed distance, never cross a page, and are cancelled on pipeline flush.

Parameters:
- vaddr_width_p, 39, virtual address width.
- stride_width_p, 8, width of signed stride (bytes).
- output_range_p, 8, width of remaining-iteration count.
- max_prefetch_p, 16, cap on requests generated per descriptor (>=1).
- prefetch_distance_p, 4, iterations ahead of the base address at which prefetching starts.
- block_offset_width_p, 6, log2 cache block bytes.
- page_offset_width_p, 12, log2 page bytes.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- loop_v_i  in  1  descriptor valid from loop inference.
- ready_and_o  out  1  descriptor accepted when loop_v_i & ready_and_o.
- remaining_iterations_i  in  output_range_p  iterations left in the loop.
- stride_i  in  stride_width_p  signed byte stride.
- base_addr_i  in  vaddr_width_p  striding load's effective address at confirmation.
- striding_pc_i  in  vaddr_width_p  PC of the striding load.
- flush_i  in  1  clear issue / npc redirect; cancels activity.
- pf_v_o  out  1  prefetch request valid.
- pf_vaddr_o  out  vaddr_width_p  prefetch virtual address.
- pf_pc_o  out  vaddr_width_p  captured striding_pc, for tagging.
- pf_yumi_i  in  1  scheduler consumed request; legal only while pf_v_o.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE, count=0, addr=0, pc=0, pf_v_o=0, busy_o=0, ready_and_o=1 in the first cycle after reset.
- FSM states: IDLE, ISSUE.
- IDLE:
  - ready_and_o=1 and pf_v_o=0.
  - On accept: stride_s = sign-extend(stride_i) to vaddr_width_p; count = min(remaining_iterations_i, max_prefetch_p).
  - addr = base_addr_i + prefetch_distance_p*stride_s, computed mod 2^vaddr_width_p. Capture pc.
  - Go to ISSUE only if count!=0, stride_i!=0, and the page of addr equals the page of base_addr_i. Otherwise stay IDLE; the descriptor is still consumed.
- ISSUE:
  - ready_and_o=0 and pf_v_o = ~flush_i. pf_vaddr_o=addr and pf_pc_o=pc are held stable until yumi.
  - On pf_yumi_i: next = addr + stride_s and count decrements.
  - Return to IDLE if count==1, or if next[vaddr_width_p-1:page_offset_width_p] != addr[vaddr_width_p-1:page_offset_width_p] (page-cross stop). Otherwise addr=next.
- Latency: the first pf_v_o is asserted the cycle after descriptor accept. Back-to-back yumi gives one request per cycle.
- flush_i has priority in any state:
  - pf_v_o is forced 0 in the same cycle.
  - Next state is IDLE and count is cleared.
  - A descriptor presented in the flush cycle is not accepted: ready_and_o=0 while flush_i.
- Yumi and flush in the same cycle: yumi is illegal because pf_v_o=0; ignore it.
- Address wrap past 2^vaddr_width_p: caught by the page-cross check, which terminates the stream.
- Reset mid-ISSUE: returns to IDLE next cycle with no request emitted.

Optional Feature:
- Macro: BP_BE_PREFETCH_LINE_DEDUP_EN.
- When defined:
  - The block tracks last_line = line of the last yumi'd address, valid per descriptor.
  - In ISSUE, if addr's line equals last_line, pf_v_o=0 and the block self-advances one iteration per cycle, as if yumi'd, with the same termination rules. This covers small strides such as 8B, which yield one request per 64B block.
- When undefined: every iteration issues a request.

Decomposition:
- Shared be package: state enum bp_be_pf_state_e {e_pf_idle, e_pf_issue} and the descriptor struct bp_be_loop_desc_s (remaining, stride, base, pc). The struct is reused by bp_be_loop_inference.
- One sub-module: bp_be_pf_addr_gen. It performs stride sign-extension, the add, and the page/line compare, and is combinational.

Test Plan:
- Basic stream: base=0x1000, stride=+64, remaining=3, distance=4 -> accept; requests 0x1100, 0x1140, 0x1180 on consecutive yumi cycles, then IDLE with ready_and_o=1.
- Cap and backpressure: remaining=200, stride=+8, yumi every 3rd cycle -> exactly 16 requests; pf_vaddr_o stable while stalled. With DEDUP_EN: 0x1020, 0x1040, ... one per line, same termination point as without the macro.
- Page cross: base=0x1F00, stride=+64, remaining=10 -> 0x1F00+256=0x2000 crosses the page at setup -> descriptor consumed, no pf_v_o. Base=0x1E00 -> 0x1F00, 0x1F40, 0x1F80, 0x1FC0, then stop.
- Negative stride: base=0x3200, stride=-32 (0xE0), remaining=2 -> 0x3180, then 0x3160.
- Flush: flush_i in the 2nd ISSUE cycle with loop_v_i held high -> pf_v_o=0 that cycle, IDLE next cycle, a new descriptor accepted the cycle after.
- Degenerate descriptors and reset: stride=0 or remaining=0 -> consumed, no requests, busy_o stays 0. reset_i mid-stream -> all outputs at reset values next cycle.
